// File: rtl/ps_video_pkg.sv
// Shared video constants and helpers for the line feeder and its grey converter.
package ps_video_pkg;

    localparam int unsigned LINE_LENGTH_DEF = 640;
    localparam int unsigned FRAME_LINES_DEF = 480;

    localparam int unsigned COEF_R = 77;
    localparam int unsigned COEF_G = 150;
    localparam int unsigned COEF_B = 29;

    localparam int unsigned PIX_W      = 16;
    localparam int unsigned GREY_W     = 8;
    localparam int unsigned SUM_W      = 16;
    localparam int unsigned LINE_CNT_W = 9;

    typedef struct packed {
        logic valid;
        logic eol;
        logic eof;
    } px_side_t;

    // MSB replication keeps full-scale channels at 255
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] c);
        return {c, c[5:4]};
    endfunction

endpackage

// File: rtl/ps_rgb2grey.sv
// Three-stage RGB565-to-grey pipeline; sideband travels alongside the pixel.
module ps_rgb2grey
    import ps_video_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd,
    input  logic              i_rd_eol,
    input  logic              i_rd_eof,
    input  logic [PIX_W-1:0]  i_pix,
    output logic [GREY_W-1:0] o_data,
    output px_side_t          o_side
);

    px_side_t          side0_q, side0_d;
    px_side_t          side1_q, side1_d;
    px_side_t          side2_q, side2_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [GREY_W-1:0] data_q, data_d;
    logic [7:0]        r8, g8, b8;

    // Stage 0 tags the read; the FIFO presents the pixel one cycle later
    always_comb begin
        side0_d       = '0;
        side0_d.valid = i_rd;
        side0_d.eol   = i_rd && i_rd_eol;
        side0_d.eof   = i_rd && i_rd_eol && i_rd_eof;
    end

    always_comb begin
        r8      = expand5(i_pix[15:11]);
        g8      = expand6(i_pix[10:5]);
        b8      = expand5(i_pix[4:0]);
        sum_d   = SUM_W'(COEF_R) * SUM_W'(r8)
                + SUM_W'(COEF_G) * SUM_W'(g8)
                + SUM_W'(COEF_B) * SUM_W'(b8);
        side1_d = side0_q;
        side2_d = side1_q;
        data_d  = data_q;
        if (side1_q.valid) begin
            data_d = sum_q[SUM_W-1 -: GREY_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            side0_q <= '0;
            side1_q <= '0;
            side2_q <= '0;
            sum_q   <= '0;
            data_q  <= '0;
        end else begin
            side0_q <= side0_d;
            side1_q <= side1_d;
            side2_q <= side2_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
        end
    end

    assign o_data = data_q;
    assign o_side = side2_q;

endmodule

// File: rtl/ps_line_feeder.sv
// Pulls one line of RGB565 pixels per request from a FIFO and emits greyscale with line/frame markers.
module ps_line_feeder
    import ps_video_pkg::*;
#(
    parameter int unsigned LINE_LENGTH = LINE_LENGTH_DEF,
    parameter int unsigned FRAME_LINES = FRAME_LINES_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PIX_W-1:0]      i_fifo_rdata,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd,
    input  logic                  i_req,
    output logic [GREY_W-1:0]     o_data,
    output logic                  o_valid,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic [LINE_CNT_W-1:0] o_line_count
);

    localparam int unsigned PIX_CNT_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int unsigned DRAIN_W   = 3;
    // Last pixel leaves 3 cycles after the final read; hold 2 more for i_req to settle
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PIX_CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  rd_c;
    logic                  last_rd_c;
    logic                  last_line_c;
    px_side_t              side;

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        rd_c        = 1'b0;
        last_rd_c   = (rd_cnt_q == PIX_CNT_W'(LINE_LENGTH - 1));
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                rd_c = !i_fifo_empty && !i_rst;
                if (rd_c) begin
                    if (last_rd_c) begin
                        rd_cnt_d    = '0;
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + PIX_CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line index advances the cycle after the eol pixel leaves
    always_comb begin
        last_line_c = (line_cnt_q == LINE_CNT_W'(FRAME_LINES - 1));
        line_cnt_d  = line_cnt_q;
        if (side.eol) begin
            line_cnt_d = last_line_c ? '0 : line_cnt_q + LINE_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    ps_rgb2grey u_rgb2grey (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rd     (rd_c),
        .i_rd_eol (last_rd_c),
        .i_rd_eof (last_line_c),
        .i_pix    (i_fifo_rdata),
        .o_data   (o_data),
        .o_side   (side)
    );

    assign o_fifo_rd    = rd_c;
    assign o_valid      = side.valid;
    assign o_eol        = side.eol;
    assign o_eof        = side.eof;
    assign o_line_count = line_cnt_q;

endmodule

// File: tb/tb_ps_line_feeder.sv
// Randomized bench for ps_line_feeder against a FIFO model and a per-pixel reference queue.
module tb_ps_line_feeder;

    localparam int unsigned LL = 640;
    localparam int unsigned FL = 12;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_fifo_rdata;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic        i_req;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_eol;
    logic        o_eof;
    logic [8:0]  o_line_count;

    typedef struct {
        logic [15:0] px;
        int          due;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk_en = 0;
    bit          tb_rst = 1;
    bit          tb_req = 0;
    int          stall  = 0;
    logic [15:0] fifo_q[$];
    exp_t        exp_q[$];
    logic [15:0] pend;
    bit          pend_v = 0;
    int          m_pix = 0;
    int          m_line = 0;
    int          line_reads = 0;
    bit          eol_pending = 0;
    int          last_eol_cyc = -100;
    int          first_rd_cyc = 0;
    int          n_reads = 0;
    int          eol_cnt = 0;
    int          eof_cnt = 0;
    int          out_cnt = 0;

    ps_line_feeder #(.LINE_LENGTH(LL), .FRAME_LINES(FL)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fifo_rdata (i_fifo_rdata),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .i_req        (i_req),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_eol        (o_eol),
        .o_eof        (o_eof),
        .o_line_count (o_line_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int grey(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    // One clock: check outputs, present FIFO data, observe the read strobe
    task automatic tick();
        exp_t       e;
        bit         want_v, want_eol, want_eof;
        logic [7:0] want_data;
        @(negedge i_clk);
        cyc++;
        want_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        want_eol = 1'b0;
        want_eof = 1'b0;
        if (chk_en) begin
            total++;
            if (o_valid !== want_v) begin
                bad++;
                $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, o_valid, want_v);
            end
            if (want_v) begin
                e = exp_q.pop_front();
                want_data = 8'(grey(e.px));
                want_eol  = (m_pix == LL - 1);
                want_eof  = want_eol && (m_line == FL - 1);
                total++;
                if (o_data !== want_data) begin
                    bad++;
                    $display("FAIL data cyc=%0d px=%h got=%0d exp=%0d", cyc, e.px, o_data, want_data);
                end
            end
            total++;
            if (o_eol !== want_eol) begin
                bad++;
                $display("FAIL eol cyc=%0d got=%b exp=%b", cyc, o_eol, want_eol);
            end
            total++;
            if (o_eof !== want_eof) begin
                bad++;
                $display("FAIL eof cyc=%0d got=%b exp=%b", cyc, o_eof, want_eof);
            end
            total++;
            if (o_line_count !== 9'(m_line)) begin
                bad++;
                $display("FAIL line_count cyc=%0d got=%0d exp=%0d", cyc, o_line_count, m_line);
            end
            if (want_v) begin
                out_cnt++;
                if (want_eol) begin
                    eol_cnt++;
                    if (want_eof) eof_cnt++;
                    last_eol_cyc = cyc;
                    eol_pending  = 1'b0;
                    m_pix  = 0;
                    m_line = (m_line + 1) % FL;
                end else begin
                    m_pix++;
                end
            end
        end
        i_rst        = tb_rst;
        i_req        = tb_req;
        i_fifo_rdata = pend_v ? pend : 16'($urandom);
        pend_v       = 1'b0;
        i_fifo_empty = (stall > 0) || (fifo_q.size() == 0);
        if (stall > 0) stall--;
        #1;
        if (chk_en && (tb_rst || i_fifo_empty)) begin
            total++;
            if (o_fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL rd_blocked cyc=%0d got=%b exp=0 rst=%b empty=%b", cyc, o_fifo_rd, tb_rst, i_fifo_empty);
            end
        end
        if (chk_en && o_fifo_rd === 1'b1 && !i_fifo_empty && !tb_rst) begin
            if (line_reads == LL) begin
                total++;
                if (eol_pending || cyc < last_eol_cyc + 3) begin
                    bad++;
                    $display("FAIL early_read cyc=%0d got_gap=%0d exp_gap>=3 eol_pending=%b", cyc, cyc - last_eol_cyc, eol_pending);
                end
                line_reads = 0;
            end
            pend   = fifo_q.pop_front();
            pend_v = 1'b1;
            exp_q.push_back('{pend, cyc + 3});
            line_reads++;
            n_reads++;
            if (line_reads == 1) first_rd_cyc = cyc;
            if (line_reads == LL) eol_pending = 1'b1;
        end
        if (tb_rst) begin
            exp_q.delete();
            m_pix       = 0;
            m_line      = 0;
            line_reads  = 0;
            eol_pending = 1'b0;
            pend_v      = 1'b0;
        end
        if (bad > 200) begin
            $display("FAIL abort too_many_errors got=%0d exp=0", bad);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "aborting");
        end
    endtask

    task automatic fill(input int n, input bit white);
        for (int i = 0; i < n; i++) fifo_q.push_back(white ? 16'hFFFF : 16'($urandom));
    endtask

    task automatic drain_ticks();
        tb_req = 1'b0;
        repeat (8) tick();
    endtask

    // Request one line and run until its eol pixel; checks read count and timeout
    task automatic run_line(input int drop_at, input int stall_at, input bit rand_stall);
        int  start_r, start_e, budget;
        bit  stalled;
        start_r = n_reads;
        start_e = eol_cnt;
        budget  = 0;
        stalled = 1'b0;
        tb_req  = 1'b1;
        while (eol_cnt == start_e && budget < 4000) begin
            if (n_reads - start_r >= drop_at) tb_req = 1'b0;
            if (!stalled && n_reads - start_r == stall_at) begin
                stall   = 10;
                stalled = 1'b1;
            end
            if (rand_stall && stall == 0 && $urandom_range(0, 31) == 0) stall = $urandom_range(1, 6);
            tick();
            budget++;
        end
        total++;
        if (eol_cnt == start_e) begin
            bad++;
            $display("FAIL line_timeout got_reads=%0d exp_eol_within=4000", n_reads - start_r);
        end
        total++;
        if (n_reads - start_r != LL) begin
            bad++;
            $display("FAIL line_reads got=%0d exp=%0d", n_reads - start_r, LL);
        end
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        tb_req = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        fill(4, 1'b0);
        repeat (3) tick();
        total++;
        if (o_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_data got=%0d exp=0", o_data);
        end
        tb_rst = 1'b0;
        tb_req = 1'b0;
        fifo_q.delete();
        repeat (2) tick();
    endtask

    task automatic test_white_line();
        int o0;
        o0 = out_cnt;
        fill(LL, 1'b1);
        run_line(1, -1, 1'b0);
        drain_ticks();
        total++;
        if (out_cnt - o0 != LL) begin
            bad++;
            $display("FAIL white_outputs got=%0d exp=%0d", out_cnt - o0, LL);
        end
        total++;
        if (o_line_count !== 9'd1) begin
            bad++;
            $display("FAIL white_line_count got=%0d exp=1", o_line_count);
        end
    endtask

    task automatic test_colors();
        fifo_q.push_back(16'hF800);
        fifo_q.push_back(16'h07E0);
        fifo_q.push_back(16'h001F);
        fifo_q.push_back(16'h0000);
        fill(LL - 4, 1'b0);
        run_line(1, -1, 1'b0);
        drain_ticks();
    endtask

    task automatic test_stall();
        fill(LL, 1'b0);
        run_line(1, 200, 1'b0);
        total++;
        if (last_eol_cyc - first_rd_cyc != LL - 1 + 10 + 3) begin
            bad++;
            $display("FAIL stall_span got=%0d exp=%0d", last_eol_cyc - first_rd_cyc, LL + 12);
        end
        drain_ticks();
    endtask

    task automatic test_req_drop();
        int r0;
        r0 = n_reads;
        fill(LL + 50, 1'b0);
        run_line(100, -1, 1'b0);
        repeat (30) tick();
        total++;
        if (n_reads - r0 != LL || fifo_q.size() != 50) begin
            bad++;
            $display("FAIL req_drop_reads got=%0d left=%0d exp=%0d left=50", n_reads - r0, fifo_q.size(), LL);
        end
        fifo_q.delete();
    endtask

    task automatic test_frame();
        int e0, l0;
        e0 = eof_cnt;
        l0 = m_line;
        fill(LL * FL, 1'b0);
        for (int ln = 0; ln < FL; ln++) begin
            run_line((ln == FL - 1) ? 1 : LL + 1, -1, 1'b1);
        end
        drain_ticks();
        total++;
        if (eof_cnt - e0 != 1) begin
            bad++;
            $display("FAIL frame_eof_count got=%0d exp=1", eof_cnt - e0);
        end
        total++;
        if (o_line_count !== 9'(l0)) begin
            bad++;
            $display("FAIL frame_wrap got=%0d exp=%0d", o_line_count, l0);
        end
    endtask

    task automatic test_reset_mid();
        int r0, budget;
        r0 = n_reads;
        budget = 0;
        fill(LL, 1'b0);
        tb_req = 1'b1;
        while (n_reads - r0 < 300 && budget < 2000) begin
            tick();
            budget++;
        end
        total++;
        if (n_reads - r0 != 300) begin
            bad++;
            $display("FAIL rst_mid_reach got=%0d exp=300", n_reads - r0);
        end
        tb_rst = 1'b1;
        tb_req = 1'b0;
        tick();
        tb_rst = 1'b0;
        tick();
        total++;
        if (o_valid !== 1'b0 || o_line_count !== 9'd0) begin
            bad++;
            $display("FAIL rst_mid_flush got=%b/%0d exp=0/0", o_valid, o_line_count);
        end
        fifo_q.delete();
        fill(LL, 1'b0);
        run_line(1, -1, 1'b1);
        drain_ticks();
        total++;
        if (o_line_count !== 9'd1) begin
            bad++;
            $display("FAIL rst_mid_next_line got=%0d exp=1", o_line_count);
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req        = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_rdata = 16'h0000;
        test_reset();
        test_white_line();
        test_colors();
        test_stall();
        test_req_drop();
        test_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
